// File: rtl/reg_file_scoreboard.sv
`timescale 1ns/1ps
// RV32 integer register file: 2 combinational read ports with write-through bypass, 1 sync write port,
// plus a per-register busy scoreboard; stall is combinational and issue holds while an in-use operand is pending.
module reg_file_scoreboard #(
  parameter int bits            = 32,
  parameter int no_of_registers = 32,
  parameter int addr_width_DMEM = 10
) (
  input  logic                               clk,
  input  logic                               async_reset,
  input  logic [$clog2(no_of_registers)-1:0] rs1_addr,
  input  logic [$clog2(no_of_registers)-1:0] rs2_addr,
  input  logic                               rs1_use,
  input  logic                               rs2_use,
  output logic [bits-1:0]                    rd1,
  output logic [bits-1:0]                    rd2,
  input  logic                               we,
  input  logic [$clog2(no_of_registers)-1:0] wa,
  input  logic [bits-1:0]                    wd,
  input  logic                               mark_en,
  input  logic [$clog2(no_of_registers)-1:0] mark_addr,
  output logic                               stall,
  output logic [$clog2(no_of_registers):0]   busy_count
);

  localparam int AW = $clog2(no_of_registers);
  localparam int CW = AW + 1;
  localparam logic [bits-1:0] SP_RESET = {{(bits-1){1'b0}}, 1'b1} << addr_width_DMEM;

  logic [bits-1:0]            regs_q [no_of_registers];
  logic [bits-1:0]            regs_d [no_of_registers];
  logic [no_of_registers-1:0] busy_q;
  logic [no_of_registers-1:0] busy_d;
  logic [CW-1:0]              busy_count_q;
  logic [CW-1:0]              busy_count_d;

  logic wr_en;
  logic wr_hit1;
  logic wr_hit2;
  logic busy1_eff;
  logic busy2_eff;

  assign wr_en   = we && (wa != '0);
  assign wr_hit1 = we && (wa == rs1_addr);
  assign wr_hit2 = we && (wa == rs2_addr);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wa] = wd;
    end
  end

  // A new mark beats a same-cycle write-back: the written value belongs to the older producer.
  always_comb begin
    busy_d = busy_q;
    for (int a = 1; a < no_of_registers; a++) begin
      if (mark_en && (mark_addr == AW'(a))) begin
        busy_d[a] = 1'b1;
      end else if (we && (wa == AW'(a))) begin
        busy_d[a] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_count_d = '0;
    for (int a = 1; a < no_of_registers; a++) begin
      busy_count_d = busy_count_d + CW'(busy_d[a]);
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      for (int i = 0; i < no_of_registers; i++) begin
        regs_q[i] <= (i == 2) ? SP_RESET : '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  always_comb begin
    rd1 = '0;
    if (rs1_addr != '0) begin
      rd1 = wr_hit1 ? wd : regs_q[rs1_addr];
    end
  end

  always_comb begin
    rd2 = '0;
    if (rs2_addr != '0) begin
      rd2 = wr_hit2 ? wd : regs_q[rs2_addr];
    end
  end

  // A result arriving this cycle satisfies the dependency, so it does not stall.
  assign busy1_eff  = busy_q[rs1_addr] && !wr_hit1;
  assign busy2_eff  = busy_q[rs2_addr] && !wr_hit2;
  assign stall      = (rs1_use && busy1_eff) || (rs2_use && busy2_eff);
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
`timescale 1ns/1ps
// Bench for reg_file_scoreboard: expectations are queued when stimulus is applied and
// popped against the DUT outputs once they are valid.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        async_reset;
  logic [4:0]  rs1_addr, rs2_addr, wa, mark_addr;
  logic        rs1_use, rs2_use, we, mark_en;
  logic [31:0] wd, rd1, rd2;
  logic        stall;
  logic [5:0]  busy_count;

  reg_file_scoreboard #(
    .bits(32), .no_of_registers(32), .addr_width_DMEM(10)
  ) dut (
    .clk(clk), .async_reset(async_reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_use(rs1_use), .rs2_use(rs2_use),
    .rd1(rd1), .rd2(rd2), .we(we), .wa(wa), .wd(wd),
    .mark_en(mark_en), .mark_addr(mark_addr), .stall(stall), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Reference model of architectural state
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic drain();
    string       t;
    logic [31:0] v;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      v = exp_q.pop_front();
      case (t)
        "rd1":   obs = rd1;
        "rd2":   obs = rd2;
        "stall": obs = {31'd0, stall};
        "cnt":   obs = {26'd0, busy_count};
        default: obs = 32'hxxxx_xxxx;
      endcase
      chk(t, obs, v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_regs[2] = 32'h400;
    m_busy    = 32'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_stall();
    logic b1, b2;
    b1 = m_busy[rs1_addr] && !(we && wa == rs1_addr);
    b2 = m_busy[rs2_addr] && !(we && wa == rs2_addr);
    return (rs1_use && b1) || (rs2_use && b2);
  endfunction

  task automatic model_edge();
    if (we && wa != 5'd0) m_regs[wa] = wd;
    if (we) m_busy[wa] = 1'b0;
    if (mark_en) m_busy[mark_addr] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic check_model();
    push_exp("rd1", m_read(rs1_addr));
    push_exp("rd2", m_read(rs2_addr));
    push_exp("stall", {31'd0, m_stall()});
    drain();
  endtask

  // Clock edge, then compare the registered busy count against the model.
  task automatic edge_();
    @(posedge clk);
    model_edge();
    #1;
    push_exp("cnt", $countones(m_busy));
    drain();
  endtask

  task automatic drv(input logic i_we, input logic [4:0] i_wa, input logic [31:0] i_wd,
                     input logic [4:0] i_r1, input logic [4:0] i_r2,
                     input logic i_u1, input logic i_u2,
                     input logic i_mk, input logic [4:0] i_ma);
    we = i_we; wa = i_wa; wd = i_wd;
    rs1_addr = i_r1; rs2_addr = i_r2; rs1_use = i_u1; rs2_use = i_u2;
    mark_en = i_mk; mark_addr = i_ma;
    #1;
  endtask

  initial begin
    async_reset = 1'b1;
    drv(0, 0, 0, 5'd2, 5'd0, 0, 0, 0, 0);
    model_reset();
    push_exp("rd1", 32'h400);
    push_exp("rd2", 32'd0);
    push_exp("stall", 32'd0);
    push_exp("cnt", 32'd0);
    drain();
    async_reset = 1'b0;
    edge_();

    // Write-through bypass, then stored value
    drv(1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 0, 0, 0, 0);
    push_exp("rd1", 32'hDEADBEEF); drain(); check_model();
    edge_();
    drv(0, 5'd5, 32'h0, 5'd5, 5'd0, 0, 0, 0, 0);
    push_exp("rd1", 32'hDEADBEEF); drain(); check_model();
    edge_();

    // x0 ignores writes and bypass
    drv(1, 5'd0, 32'h1234, 5'd0, 5'd0, 0, 0, 0, 0);
    push_exp("rd1", 32'd0); drain();
    edge_();
    drv(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 0);
    push_exp("rd1", 32'd0); drain();

    // Mark x7, observe stall, clear by write-back
    drv(0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 5'd7);
    edge_();
    drv(0, 0, 0, 5'd7, 5'd0, 1, 0, 0, 0);
    push_exp("stall", 32'd1); push_exp("cnt", 32'd1); drain();
    drv(0, 0, 0, 5'd7, 5'd0, 0, 0, 0, 0);
    push_exp("stall", 32'd0); drain();
    drv(1, 5'd7, 32'h55, 5'd7, 5'd0, 1, 0, 0, 0);
    push_exp("stall", 32'd0); push_exp("rd1", 32'h55); drain();
    edge_();
    push_exp("cnt", 32'd0); drain();

    // Same-cycle mark and write: mark wins
    drv(1, 5'd9, 32'hA, 5'd0, 5'd0, 0, 0, 1, 5'd9);
    edge_();
    drv(0, 0, 0, 5'd0, 5'd9, 0, 1, 0, 0);
    push_exp("stall", 32'd1); push_exp("rd2", 32'hA); push_exp("cnt", 32'd1); drain();
    drv(1, 5'd9, 32'hB, 5'd0, 5'd9, 0, 1, 0, 0);
    check_model();
    edge_();

    // Marks then mid-cycle async reset
    drv(1, 5'd3, 32'h33, 5'd0, 5'd0, 0, 0, 0, 0);
    edge_();
    for (int i = 3; i <= 5; i++) begin
      drv(0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 5'(i));
      edge_();
      push_exp("cnt", 32'(i - 2)); drain();
    end
    drv(0, 0, 0, 5'd3, 5'd2, 1, 0, 0, 0);
    push_exp("stall", 32'd1); push_exp("rd1", 32'h33); drain();
    #2;
    async_reset = 1'b1;
    #1;
    model_reset();
    push_exp("cnt", 32'd0); push_exp("stall", 32'd0);
    push_exp("rd1", 32'd0); push_exp("rd2", 32'h400);
    drain();
    async_reset = 1'b0;
    edge_();

    // First edge after deassertion performs a normal write
    drv(1, 5'd6, 32'h66, 5'd0, 5'd0, 0, 0, 0, 0);
    edge_();
    drv(0, 0, 0, 5'd6, 5'd0, 0, 0, 0, 0);
    push_exp("rd1", 32'h66); drain();

    // Marking x0 has no effect
    drv(0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 5'd0);
    edge_();
    drv(0, 0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
    push_exp("cnt", 32'd0); push_exp("stall", 32'd0); drain();

    // Fill every register, count saturates at 31; re-mark keeps single bit
    for (int i = 0; i < 32; i++) begin
      drv(0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 5'(i));
      edge_();
    end
    drv(0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 5'd12);
    edge_();
    push_exp("cnt", 32'd31); drain();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      drv(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
          5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0), 5'($urandom));
      check_model();
      edge_();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Integer register file for the RV32 core: two combinational read ports, one synchronous write port, plus a per-register busy scoreboard for multi-cycle results such as loads.
- Sits between decode, which supplies rs1/rs2/rd addresses and marks pending destinations, and write-back, which supplies the result.
- Produces operand data and a stall request for the issue stage.
- x2 (sp) resets to the top of data memory.

Parameters:
- bits, 32, data width of each register
- no_of_registers, 32, number of architectural registers; power of 2, at least 4
- addr_width_DMEM, 10, DMEM address width; sp reset value is 2**addr_width_DMEM

Ports:
- clk  input  1  clock; all state updates on rising edge
- async_reset  input  1  asynchronous, active-high reset
- rs1_addr  input  $clog2(no_of_registers)  read port 1 address
- rs2_addr  input  $clog2(no_of_registers)  read port 2 address
- rs1_use  input  1  current instruction reads rs1
- rs2_use  input  1  current instruction reads rs2
- rd1  output  bits  read port 1 data
- rd2  output  bits  read port 2 data
- we  input  1  write-back enable
- wa  input  $clog2(no_of_registers)  write-back address
- wd  input  bits  write-back data
- mark_en  input  1  issuing instruction with a pending (multi-cycle) destination
- mark_addr  input  $clog2(no_of_registers)  destination being marked busy
- stall  output  1  issue must hold this cycle
- busy_count  output  $clog2(no_of_registers)+1  number of registers currently busy

Behaviour:
- Reset, asynchronous and immediate on async_reset=1, independent of clk:
  - all registers = 0, except x2 = 2**addr_width_DMEM
  - all busy bits = 0, so busy_count=0
  - stall=0 unless an operand is in use and busy, which is impossible while in reset
  - rd1/rd2 reflect the reset contents
- Reset deassertion mid-stream: the first rising edge after deassertion performs a normal update. Reset asserted mid-operation discards all pending marks.
- Write: on a rising edge with we=1 and wa!=0, reg[wa] <= wd. Writes to x0 are ignored; x0 always reads 0.
- Read:
  - rdN = 0 if rsN_addr==0.
  - Otherwise, write-through bypass: rdN = wd if we=1 and wa==rsN_addr.
  - Otherwise rdN = reg[rsN_addr].
  - Zero-cycle combinational latency.
- Effective busy: busyN_eff = busy[rsN_addr] & ~(we & wa==rsN_addr). A same-cycle write-back satisfies the dependency.
- stall = (rs1_use & busyN_eff for rs1) | (rs2_use & busyN_eff for rs2). Combinational. x0 is never busy.
- Scoreboard update per rising edge, for each address a:
  - set if mark_en=1, mark_addr==a, a!=0
  - else clear if we=1, wa==a
  - else hold
- Simultaneous mark and write to the same address: mark wins, busy stays 1. The old result is written; the new producer is pending.
- Mark of an already-busy register: stays busy (single bit, no counting).
- Write to a non-busy register: data written, busy unchanged at 0.
- Upstream must not assert mark_en while stall=1; a mark under stall is still honoured.
- busy_count: registered; equals the popcount of the busy bits after each edge. Reaches no_of_registers-1 maximum (x0 excluded). No overflow.
- No X propagation: all storage initialised by reset.

Test Plan:
- Reset, then read rs1=2, rs2=0 -> rd1=0x400 (addr_width_DMEM=10), rd2=0, stall=0, busy_count=0.
- we=1, wa=5, wd=0xDEADBEEF with rs1_addr=5 in the same cycle -> rd1=0xDEADBEEF combinationally; after the edge, with we=0, rd1 still 0xDEADBEEF. we=1, wa=0, wd=0x1234 -> x0 reads 0.
- mark_en=1, mark_addr=7; next cycle rs1_addr=7, rs1_use=1 -> stall=1, busy_count=1. Same with rs1_use=0 -> stall=0. Then we=1, wa=7, wd=0x55 -> stall=0 in that cycle, rd1=0x55. Next cycle busy_count=0.
- Same cycle: mark_en=1, mark_addr=9, we=1, wa=9, wd=0xA -> after the edge reg[9]=0xA, busy[9]=1, stall=1 for rs2_addr=9, rs2_use=1.
- Mark x3, x4, x5 on consecutive cycles -> busy_count 1,2,3. Assert async_reset between clock edges -> busy_count=0, stall=0, x3=0, x2=0x400 immediately, with no clock edge.
- mark_en=1, mark_addr=0 -> busy_count stays 0; rs1_addr=0, rs1_use=1 -> stall=0.
